// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//   Raster timing generator for the RGB LCD path, clocked entirely by the
//   pixel clock. A horizontal/vertical counter pair drives undelayed pixel
//   coordinates and region flags for the pixel stage. The panel sync/DE pins
//   are delayed by PIPE cycles so they line up with the render latency.
//
// Ports
//   i_clk     pixel clock, all logic on its rising edge
//   i_rst     synchronous active-high reset
//   o_x/o_y   active pixel column/line, 0 outside the active area
//   o_hde     horizontal active (undelayed)
//   o_vde     vertical active (undelayed)
//   o_sof     high on the cycle with h=0, v=0 (undelayed)
//   o_frame   13-bit frame counter, wraps silently
//   o_hsync   panel HSYNC, delayed PIPE cycles, polarity SYNC_POL
//   o_vsync   panel VSYNC, delayed PIPE cycles, polarity SYNC_POL
//   o_de      panel DE (hde & vde), delayed PIPE cycles
module lcd_timing_gen #(
    parameter int          H_ACTIVE = 480,
    parameter int          H_FP     = 2,
    parameter int          H_SYNC   = 41,
    parameter int          H_BP     = 2,
    parameter int          V_ACTIVE = 272,
    parameter int          V_FP     = 2,
    parameter int          V_SYNC   = 10,
    parameter int          V_BP     = 2,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [8:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_hde,
    output logic        o_vde,
    output logic        o_sof,
    output logic [12:0] o_frame,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [12:0] frame_q, frame_d;
    logic        h_wrap;

    logic hde, vde, hsync_t, vsync_t;
    logic hs_dly, vs_dly, de_dly;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap)
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        // Count the frame on the edge that lands on (0,0); the reset
        // release edge moves h to 1, so it never counts.
        frame_d = ((h_cnt_d == 10'd0) && (v_cnt_d == 10'd0)) ? frame_q + 13'd1 : frame_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            frame_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            frame_q <= frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Region decode (undelayed)
    // ------------------------------------------------------------------
    always_comb begin
        hde     = (h_cnt_q < H_ACT);
        vde     = (v_cnt_q < V_ACT);
        hsync_t = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        vsync_t = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
    end

    assign o_hde   = hde;
    assign o_vde   = vde;
    assign o_x     = hde ? h_cnt_q[8:0] : 9'd0;
    assign o_y     = vde ? v_cnt_q[8:0] : 9'd0;
    assign o_sof   = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    assign o_frame = frame_q;

    // ------------------------------------------------------------------
    // Panel delay line: {hsync, vsync, de}; flushed to 0 by reset so the
    // panel sees inactive sync and DE low until fresh timing shifts in.
    // ------------------------------------------------------------------
    generate
        if (PIPE == 0) begin : g_nodly
            assign hs_dly = hsync_t;
            assign vs_dly = vsync_t;
            assign de_dly = hde & vde;
        end else begin : g_dly
            logic [2:0] dly_q [PIPE];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < int'(PIPE); i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= {hsync_t, vsync_t, hde & vde};
                    for (int i = 1; i < int'(PIPE); i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign hs_dly = dly_q[PIPE-1][2];
            assign vs_dly = dly_q[PIPE-1][1];
            assign de_dly = dly_q[PIPE-1][0];
        end
    endgenerate

    assign o_hsync = SYNC_POL ? hs_dly : ~hs_dly;
    assign o_vsync = SYNC_POL ? vs_dly : ~vs_dly;
    assign o_de    = de_dly;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen. Four instances share clock and reset:
//   [0] small raster, PIPE=2, active-low sync
//   [1] small raster, PIPE=0, active-low sync
//   [2] small raster, PIPE=7, active-high sync
//   [3] 2x2 raster,   PIPE=1 (4-cycle frame, used to reach the frame wrap)
// The reference model tracks cycles since reset and derives h/v by division.
module tb_lcd_timing_gen;

    localparam int MHA = 16, MHFP = 2, MHS = 5, MHBP = 3;
    localparam int MVA = 6,  MVFP = 2, MVS = 3, MVBP = 2;
    localparam int MHT = MHA + MHFP + MHS + MHBP;   // 26
    localparam int MVT = MVA + MVFP + MVS + MVBP;   // 13
    localparam int MFR = MHT * MVT;                 // 338
    localparam int WHT = 2, WVT = 2, WFR = WHT * WVT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [8:0]  ox [4];
    logic [8:0]  oy [4];
    logic        ohde [4];
    logic        ovde [4];
    logic        osof [4];
    logic [12:0] ofr [4];
    logic        ohs [4];
    logic        ovs [4];
    logic        ode [4];

    lcd_timing_gen #(.H_ACTIVE(MHA), .H_FP(MHFP), .H_SYNC(MHS), .H_BP(MHBP),
                     .V_ACTIVE(MVA), .V_FP(MVFP), .V_SYNC(MVS), .V_BP(MVBP),
                     .SYNC_POL(1'b0), .PIPE(2)) u_p2 (
        .i_clk(clk), .i_rst(rst), .o_x(ox[0]), .o_y(oy[0]), .o_hde(ohde[0]),
        .o_vde(ovde[0]), .o_sof(osof[0]), .o_frame(ofr[0]), .o_hsync(ohs[0]),
        .o_vsync(ovs[0]), .o_de(ode[0]));

    lcd_timing_gen #(.H_ACTIVE(MHA), .H_FP(MHFP), .H_SYNC(MHS), .H_BP(MHBP),
                     .V_ACTIVE(MVA), .V_FP(MVFP), .V_SYNC(MVS), .V_BP(MVBP),
                     .SYNC_POL(1'b0), .PIPE(0)) u_p0 (
        .i_clk(clk), .i_rst(rst), .o_x(ox[1]), .o_y(oy[1]), .o_hde(ohde[1]),
        .o_vde(ovde[1]), .o_sof(osof[1]), .o_frame(ofr[1]), .o_hsync(ohs[1]),
        .o_vsync(ovs[1]), .o_de(ode[1]));

    lcd_timing_gen #(.H_ACTIVE(MHA), .H_FP(MHFP), .H_SYNC(MHS), .H_BP(MHBP),
                     .V_ACTIVE(MVA), .V_FP(MVFP), .V_SYNC(MVS), .V_BP(MVBP),
                     .SYNC_POL(1'b1), .PIPE(7)) u_p7 (
        .i_clk(clk), .i_rst(rst), .o_x(ox[2]), .o_y(oy[2]), .o_hde(ohde[2]),
        .o_vde(ovde[2]), .o_sof(osof[2]), .o_frame(ofr[2]), .o_hsync(ohs[2]),
        .o_vsync(ovs[2]), .o_de(ode[2]));

    lcd_timing_gen #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(1), .H_BP(0),
                     .V_ACTIVE(1), .V_FP(0), .V_SYNC(1), .V_BP(0),
                     .SYNC_POL(1'b0), .PIPE(1)) u_w (
        .i_clk(clk), .i_rst(rst), .o_x(ox[3]), .o_y(oy[3]), .o_hde(ohde[3]),
        .o_vde(ovde[3]), .o_sof(osof[3]), .o_frame(ofr[3]), .o_hsync(ohs[3]),
        .o_vsync(ovs[3]), .o_de(ode[3]));

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int t  = 0;            // cycles since the last reset edge
    int fm = 0, fw = 0;    // expected frame counters
    bit [2:0] q2[$], q7[$], qw[$];   // {hsync, vsync, de} history, oldest first

    // Undelayed {hsync, vsync, de} at cycle tt for the small (w=0) or 2x2 raster.
    function automatic bit [2:0] und(bit w, int tt);
        int ht, vt, ha, va, hss, hse, vss, vse, h, v;
        if (w) begin
            ht = WHT; vt = WVT; ha = 1; va = 1; hss = 1; hse = 2; vss = 1; vse = 2;
        end else begin
            ht = MHT; vt = MVT; ha = MHA; va = MVA;
            hss = MHA + MHFP; hse = hss + MHS; vss = MVA + MVFP; vse = vss + MVS;
        end
        h = tt % ht;
        v = (tt / ht) % vt;
        return {h >= hss && h < hse, v >= vss && v < vse, h < ha && v < va};
    endfunction

    // Expected full output vector for instance 0 (k=0) or 3 (k=3).
    function automatic logic [36:0] exp_full(int k);
        int ht, vt, ha, va, h, v;
        bit [2:0] d;
        logic [12:0] fr;
        if (k == 3) begin
            ht = WHT; vt = WVT; ha = 1; va = 1; d = qw[0]; fr = 13'(fw);
        end else begin
            ht = MHT; vt = MVT; ha = MHA; va = MVA; d = q2[0]; fr = 13'(fm);
        end
        h = t % ht;
        v = (t / ht) % vt;
        return {9'(h < ha ? h : 0), 9'(v < va ? v : 0), h < ha, v < va,
                h == 0 && v == 0, fr, ~d[2], ~d[1], d[0]};
    endfunction

    function automatic logic [36:0] act_full(int k);
        return {ox[k], oy[k], ohde[k], ovde[k], osof[k], ofr[k], ohs[k], ovs[k], ode[k]};
    endfunction

    // Drive reset for one edge, advance the model, land on the falling edge.
    task automatic step(input bit r);
        bit [2:0] cm, cw;
        rst = r;
        @(posedge clk);
        cm = und(1'b0, t);
        cw = und(1'b1, t);
        if (r) begin
            t = 0; fm = 0; fw = 0;
            q2 = {3'b0, 3'b0};
            q7 = {3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0};
            qw = {3'b0};
        end else begin
            q2.push_back(cm); void'(q2.pop_front());
            q7.push_back(cm); void'(q7.pop_front());
            qw.push_back(cw); void'(qw.pop_front());
            t++;
            if (t % MFR == 0) fm = (fm + 1) % 8192;
            if (t % WFR == 0) fw = (fw + 1) % 8192;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            n_tests++;
            if ({ode[0], ohs[0], ovs[0], ofr[0], ox[0], osof[0]} !== {1'b0, 1'b1, 1'b1, 13'd0, 9'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got de=%b hs=%b vs=%b fr=%0d x=%0d sof=%b want 0 1 1 0 0 1",
                         i, ode[0], ohs[0], ovs[0], ofr[0], ox[0], osof[0]);
            end
        end
        step(1'b0);
        n_tests++;
        if (ox[0] !== 9'd1 || oy[0] !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_release got x=%0d y=%0d want x=1 y=0", ox[0], oy[0]);
        end
    endtask

    task automatic test_line();
        int hde_cnt = 0, hs_first = -1, hs_cnt = 0;
        step(1'b1);
        for (int n = 0; n < MHT; n++) begin
            if (ohde[0] === 1'b1) hde_cnt++;
            if (ohs[0] === 1'b0) begin
                if (hs_first < 0) hs_first = n;
                hs_cnt++;
            end
            step(1'b0);
        end
        n_tests++;
        if (hde_cnt != MHA) begin
            n_fail++; $display("FAIL line_hde_count got %0d want %0d", hde_cnt, MHA);
        end
        n_tests++;
        if (hs_first != MHA + MHFP + 2 || hs_cnt != MHS) begin
            n_fail++;
            $display("FAIL line_hsync got start=%0d len=%0d want start=%0d len=%0d",
                     hs_first, hs_cnt, MHA + MHFP + 2, MHS);
        end
        n_tests++;
        if ({ohde[0], ox[0], oy[0]} !== {1'b1, 9'd0, 9'd1}) begin
            n_fail++;
            $display("FAIL line_next got hde=%b x=%0d y=%0d want 1 0 1", ohde[0], ox[0], oy[0]);
        end
    endtask

    task automatic test_frame();
        int sof1 = -1, sof2 = -1, dec = 0, vsf = -1, vsc = 0;
        step(1'b1);
        for (int n = 0; n <= 2 * MFR; n++) begin
            if (n > 0 && osof[0] === 1'b1) begin
                if (sof1 < 0) sof1 = n;
                else if (sof2 < 0) sof2 = n;
            end
            if (n >= 2 && n < MFR + 2) begin
                if (ode[0] === 1'b1) dec++;
                if (ovs[0] === 1'b0) begin
                    if (vsf < 0) vsf = n;
                    vsc++;
                end
            end
            if (n == MFR) begin
                n_tests++;
                if (ofr[0] !== 13'd1) begin
                    n_fail++; $display("FAIL frame_count got %0d want 1", ofr[0]);
                end
            end
            step(1'b0);
        end
        n_tests++;
        if (sof1 != MFR || sof2 != 2 * MFR) begin
            n_fail++;
            $display("FAIL frame_sof_period got %0d,%0d want %0d,%0d", sof1, sof2, MFR, 2 * MFR);
        end
        n_tests++;
        if (dec != MHA * MVA) begin
            n_fail++; $display("FAIL frame_de_count got %0d want %0d", dec, MHA * MVA);
        end
        n_tests++;
        if (vsf != (MVA + MVFP) * MHT + 2 || vsc != MVS * MHT) begin
            n_fail++;
            $display("FAIL frame_vsync got start=%0d len=%0d want start=%0d len=%0d",
                     vsf, vsc, (MVA + MVFP) * MHT + 2, MVS * MHT);
        end
    endtask

    task automatic test_pipe_variants();
        int r0 = -1, r7 = -1;
        step(1'b1);
        n_tests++;
        if (ohs[2] !== 1'b0 || ohs[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pipe_sync_idle got p7_hs=%b p0_hs=%b want 0 1", ohs[2], ohs[1]);
        end
        for (int n = 0; n < 20; n++) begin
            if (ode[1] === 1'b1 && r0 < 0) r0 = n;
            if (ode[2] === 1'b1 && r7 < 0) r7 = n;
            step(1'b0);
        end
        n_tests++;
        if (r0 != 0 || r7 != 7) begin
            n_fail++;
            $display("FAIL pipe_de_rise got p0=%0d p7=%0d want 0 7", r0, r7);
        end
    endtask

    task automatic test_mid_reset();
        int k, guard;
        step(1'b1);
        guard = 0;
        while (t != 5 * MHT + 10 && guard < 4 * MFR) begin
            step(1'b0); guard++;
        end
        step(1'b1);
        n_tests++;
        if ({ox[0], oy[0], osof[0], ode[0]} !== {9'd0, 9'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_cnt got x=%0d y=%0d sof=%b de=%b want 0 0 1 0",
                     ox[0], oy[0], osof[0], ode[0]);
        end
        step(1'b0);
        n_tests++;
        if (ode[0] !== 1'b0 || ox[0] !== 9'd1) begin
            n_fail++; $display("FAIL midrst_flush got de=%b x=%0d want 0 1", ode[0], ox[0]);
        end
        step(1'b0);
        n_tests++;
        if (ode[0] !== 1'b1) begin
            n_fail++; $display("FAIL midrst_de_return got de=%b want 1", ode[0]);
        end
        k = 2;
        while (osof[0] !== 1'b1 && k < 2 * MFR) begin
            step(1'b0); k++;
        end
        n_tests++;
        if (k != MFR) begin
            n_fail++; $display("FAIL midrst_period got %0d want %0d", k, MFR);
        end
    endtask

    task automatic test_random();
        logic [36:0] e, a;
        logic [2:0]  e3, a3;
        bit [2:0]    c;
        step(1'b1);
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k += 3) begin
                e = exp_full(k); a = act_full(k);
                n_tests++;
                if (a !== e) begin
                    n_fail++; $display("FAIL rand_full[%0d] t=%0d got %h want %h", k, t, a, e);
                end
            end
            c  = und(1'b0, t);
            e3 = {~c[2], ~c[1], c[0]};
            a3 = {ohs[1], ovs[1], ode[1]};
            n_tests++;
            if (a3 !== e3) begin
                n_fail++; $display("FAIL rand_p0 t=%0d got %b want %b", t, a3, e3);
            end
            e3 = q7[0];
            a3 = {ohs[2], ovs[2], ode[2]};
            n_tests++;
            if (a3 !== e3) begin
                n_fail++; $display("FAIL rand_p7 t=%0d got %b want %b", t, a3, e3);
            end
            step($urandom_range(0, 199) == 0);
        end
    endtask

    task automatic test_frame_wrap();
        step(1'b1);
        while (t < WFR * 8192 - 1) begin
            if (t == WFR) begin
                n_tests++;
                if (ofr[3] !== 13'd1) begin
                    n_fail++; $display("FAIL wrap_first got %0d want 1", ofr[3]);
                end
            end
            step(1'b0);
        end
        n_tests++;
        if (ofr[3] !== 13'd8191 || osof[3] !== 1'b0) begin
            n_fail++; $display("FAIL wrap_pre got fr=%0d sof=%b want 8191 0", ofr[3], osof[3]);
        end
        step(1'b0);
        n_tests++;
        if (ofr[3] !== 13'd0 || osof[3] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_post got fr=%0d sof=%b want 0 1", ofr[3], osof[3]);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_line();
        test_frame();
        test_pipe_variants();
        test_mid_reset();
        test_random();
        test_frame_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
